alu_sequencer: RTL and testbench

//  Shares one combinational 32-bit ALU between two requesters. Arbitrates

---
 rtl/alu_sequencer.sv | 113 +++++++++++
 tb/tb_alu_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Round-robin sequencer that shares one external combinational ALU between two requesters,
// holding operands for a fixed settle time and returning the captured result over valid/ready.
module alu_sequencer #(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [5:0]           req_cmd,
  input  logic [2*WIDTH-1:0]   req_a,
  input  logic [2*WIDTH-1:0]   req_b,
  output logic [1:0]           rsp_valid,
  input  logic [1:0]           rsp_ready,
  output logic [WIDTH-1:0]     rsp_result,
  output logic [2:0]           rsp_flags,
  output logic [2:0]           alu_command,
  output logic [WIDTH-1:0]     alu_operandA,
  output logic [WIDTH-1:0]     alu_operandB,
  input  logic [WIDTH-1:0]     alu_result,
  input  logic                 alu_carryout,
  input  logic                 alu_zero,
  input  logic                 alu_overflow,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] op_count
);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_reg;
  logic             rr_ptr_reg;
  logic             owner_reg;
  logic [SW-1:0]    settle_cnt_reg;
  logic             grant;
  logic [2:0]       cmd_arr [2];
  logic [WIDTH-1:0] a_arr   [2];
  logic [WIDTH-1:0] b_arr   [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
    assign cmd_arr[gi] = req_cmd[gi*3 +: 3];
    assign a_arr[gi]   = req_a[gi*WIDTH +: WIDTH];
    assign b_arr[gi]   = req_b[gi*WIDTH +: WIDTH];
  end

  // A lone requester wins outright; the pointer only breaks ties.
  always_comb begin
    grant = rr_ptr_reg;
    if (req_valid == 2'b01)
      grant = 1'b0;
    else if (req_valid == 2'b10)
      grant = 1'b1;
  end

  always_comb begin
    req_ready = 2'b00;
    if (!reset && state_reg == IDLE && req_valid[grant])
      req_ready = grant ? 2'b10 : 2'b01;
  end

  assign busy = (state_reg != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      rr_ptr_reg     <= 1'b0;
      owner_reg      <= 1'b0;
      settle_cnt_reg <= '0;
      rsp_valid      <= 2'b00;
      rsp_result     <= '0;
      rsp_flags      <= 3'b000;
      alu_command    <= 3'b000;
      alu_operandA   <= '0;
      alu_operandB   <= '0;
      op_count       <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|req_ready) begin
            alu_command    <= cmd_arr[grant];
            alu_operandA   <= a_arr[grant];
            alu_operandB   <= b_arr[grant];
            owner_reg      <= grant;
            rr_ptr_reg     <= ~grant;
            settle_cnt_reg <= SW'(SETTLE_CYCLES);
            state_reg      <= EXEC;
          end
        end
        EXEC: begin
          // Capture on the edge that closes the final settle cycle.
          if (settle_cnt_reg == SW'(1)) begin
            rsp_result <= alu_result;
            rsp_flags  <= {alu_overflow, alu_carryout, alu_zero};
            rsp_valid  <= owner_reg ? 2'b10 : 2'b01;
            state_reg  <= RESP;
          end else begin
            settle_cnt_reg <= settle_cnt_reg - SW'(1);
          end
        end
        RESP: begin
          if (rsp_ready[owner_reg]) begin
            rsp_valid <= 2'b00;
            op_count  <= op_count + CNT_WIDTH'(1);
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: an ALU model sits on the alu_* ports, and every expected response
// comes from the operands the bench itself presented plus a round-robin/count model.
module tb_alu_sequencer;
  localparam int W      = 32;
  localparam int SETTLE = 2;
  localparam int CW     = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [5:0]    req_cmd;
  logic [2*W-1:0] req_a, req_b;
  logic [W-1:0]  rsp_result, alu_operandA, alu_operandB, alu_result;
  logic [2:0]    rsp_flags, alu_command;
  logic          alu_carryout, alu_zero, alu_overflow, busy;
  logic [CW-1:0] op_count;

  int n_checks = 0;
  int n_pass   = 0;
  int cycle    = 0;
  int model_rr = 0;
  int model_count = 0;
  int last_acc = 0;
  bit have_last = 0;
  bit spacing_on = 0;

  alu_sequencer #(.WIDTH(W), .SETTLE_CYCLES(SETTLE), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .alu_command(alu_command), .alu_operandA(alu_operandA), .alu_operandB(alu_operandB),
    .alu_result(alu_result), .alu_carryout(alu_carryout), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow), .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Returns {overflow, carryout, zero, result}.
  function automatic logic [W+2:0] alu_model(input logic [2:0] c, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         co, ov;
    co = 1'b0;
    ov = 1'b0;
    s  = '0;
    case (c)
      3'd0: begin
        s  = {1'b0, a} + {1'b0, b};
        r  = s[W-1:0];
        co = s[W];
        ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      3'd1: begin
        s  = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
        r  = s[W-1:0];
        co = s[W];
        ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      3'd2: r = a ^ b;
      3'd3: r = ($signed(a) < $signed(b)) ? {{(W-1){1'b0}}, 1'b1} : '0;
      3'd4: r = a & b;
      3'd5: r = ~(a & b);
      3'd6: r = ~(a | b);
      default: r = a | b;
    endcase
    return {ov, co, (r == '0), r};
  endfunction

  always_comb {alu_overflow, alu_carryout, alu_zero, alu_result} =
      alu_model(alu_command, alu_operandA, alu_operandB);

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic set_req(input int i, input logic [2:0] c, input logic [W-1:0] a,
                         input logic [W-1:0] b);
    req_cmd[i*3 +: 3] = c;
    req_a[i*W +: W]   = a;
    req_b[i*W +: W]   = b;
  endtask

  task automatic randomize_data();
    req_cmd = 6'($urandom);
    req_a   = {$urandom(), $urandom()};
    req_b   = {$urandom(), $urandom()};
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 2'b00);
    check({tag, "_rsp_valid"}, rsp_valid, 2'b00);
    check({tag, "_rsp_data"}, {rsp_flags, rsp_result}, '0);
    check({tag, "_alu_bus"}, {alu_command, alu_operandA, alu_operandB}, '0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_op_count"}, op_count, '0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk); #1;
    check_reset_outputs("rst");
    reset = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    model_count = 0;
    model_rr = 0;
    have_last = 0;
  endtask

  // Called from an IDLE cycle, just after a negedge; returns the same way.
  task automatic run_op(input logic [1:0] v, input int stall, input bit keep);
    int g, k;
    logic [1:0]   own;
    logic [2:0]   ec;
    logic [W-1:0] ea, eb;
    logic [W+2:0] e;
    logic [127:0] snap;
    req_valid = v;
    #1;
    g   = (v == 2'b11) ? model_rr : (v[1] ? 1 : 0);
    own = (g == 1) ? 2'b10 : 2'b01;
    check("req_ready", req_ready, own);
    check("idle_rsp_valid", rsp_valid, 2'b00);
    ec = req_cmd[g*3 +: 3];
    ea = req_a[g*W +: W];
    eb = req_b[g*W +: W];
    e  = alu_model(ec, ea, eb);
    model_rr = 1 - g;
    if (spacing_on && have_last) check("spacing", cycle - last_acc, SETTLE + 2);
    last_acc  = cycle;
    have_last = 1;
    @(negedge clk); #1;
    if (!keep) begin
      req_valid = 2'b00;
      randomize_data();
    end
    #1;
    check("alu_bus", {alu_command, alu_operandA, alu_operandB}, {ec, ea, eb});
    check("busy_exec", busy, 1'b1);
    check("ready_exec", req_ready, 2'b00);
    k = 1;
    while (rsp_valid == 2'b00 && k < 20) begin
      @(negedge clk); #1;
      k++;
    end
    check("latency", k, SETTLE + 1);
    check("rsp_valid", rsp_valid, own);
    check("rsp_result", rsp_result, e[W-1:0]);
    check("rsp_flags", rsp_flags, e[W+2:W]);
    check("count_hold", op_count, model_count);
    snap = {rsp_valid, rsp_flags, rsp_result, alu_command, alu_operandA, alu_operandB};
    for (int s = 0; s < stall; s++) begin
      rsp_ready = $urandom_range(0, 1) ? ~own : 2'b00;
      @(negedge clk); #1;
      check("resp_hold", {rsp_valid, rsp_flags, rsp_result, alu_command, alu_operandA,
                          alu_operandB}, snap);
      check("ready_resp", req_ready, 2'b00);
    end
    rsp_ready = own | ($urandom_range(0, 1) ? ~own : 2'b00);
    @(negedge clk); #1;
    rsp_ready = 2'b00;
    model_count = (model_count + 1) % (1 << CW);
    check("op_count", op_count, model_count);
    check("rsp_drop", rsp_valid, 2'b00);
    check("busy_idle", busy, 1'b0);
  endtask

  function automatic logic [1:0] rand_valid();
    case ($urandom_range(0, 2))
      0:       return 2'b01;
      1:       return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    randomize_data();
    // Reset held with random activity on every input.
    repeat (3) begin
      @(negedge clk);
      req_valid = 2'($urandom);
      rsp_ready = 2'($urandom);
      randomize_data();
      #1;
      check_reset_outputs("reset_hold");
    end
    @(negedge clk);
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    reset = 1'b0;
    #1;

    // Contention from reset: requester 0 first, then strict alternation.
    set_req(0, 3'd2, 32'hAAAAAAAA, 32'h33333333);
    set_req(1, 3'd1, 32'hAAAAAAAA, 32'h55555555);
    run_op(2'b11, 0, 1);
    set_req(1, 3'd1, 32'hAAAAAAAA, 32'h55555555);
    run_op(2'b11, 0, 1);
    randomize_data();
    run_op(2'b11, 1, 1);
    randomize_data();
    run_op(2'b11, 0, 1);
    req_valid = 2'b00;

    // Single sub whose result is zero with carry set.
    set_req(0, 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op(2'b01, 0, 0);

    // Long backpressure with the wrong owner's ready wiggling.
    randomize_data();
    run_op(2'b10, 10, 0);

    // Abort during EXEC: no response may follow.
    set_req(1, 3'd0, 32'd1, 32'd1);
    req_valid = 2'b10;
    @(negedge clk); #1;
    req_valid = 2'b00;
    check("abort_in_exec", busy, 1'b1);
    reset = 1'b1;
    repeat (3) begin
      req_valid = 2'($urandom);
      rsp_ready = 2'($urandom);
      randomize_data();
      #1;
      check_reset_outputs("abort");
      @(negedge clk); #1;
    end
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    reset = 1'b0;
    model_count = 0;
    model_rr = 0;
    have_last = 0;
    repeat (6) begin
      @(negedge clk); #1;
      check("abort_no_rsp", {busy, rsp_valid}, 3'b000);
    end
    set_req(0, 3'd0, $urandom(), $urandom());
    run_op(2'b01, 0, 0);

    // Counter wrap with back-to-back ops.
    do_reset();
    spacing_on = 1;
    for (int i = 0; i < 16; i++) begin
      randomize_data();
      run_op(rand_valid(), 0, 0);
    end
    spacing_on = 0;
    check("wrap_zero", op_count, '0);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      randomize_data();
      run_op(rand_valid(), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end
    req_valid = 2'b00;

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
